// File: rtl/adc_if_pkg.sv
// ============================================================================
// Module   : adc_if_pkg
// Purpose  : Shared definitions for the ADC lane alignment block: training
//            FSM state encoding and default rise/fall training words.
// Config   : ADC_ALIGN_ERRCNT_EN (consumed by adc_lane_align, not here)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package adc_if_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_SETTLE = 3'd2,
        ST_CHECK  = 3'd3,
        ST_EVAL   = 3'd4,
        ST_APPLY  = 3'd5
    } align_state_t;

    localparam logic [7:0] DEF_PATTERN_P = 8'hA5;
    localparam logic [7:0] DEF_PATTERN_N = 8'h5A;

endpackage

`default_nettype wire

// File: rtl/adc_lane_window.sv
// ============================================================================
// Module   : adc_lane_window
// Purpose  : Tracks the first contiguous passing tap window of one lane and
//            reports its centre.
// Ports    : clk, rst        - clock, async active-high reset
//            clr_i           - clear window at training start
//            load_i          - new tap loaded; arm the pass flag
//            check_i         - pattern compare cycle
//            mismatch_i      - lane data differs from training word
//            eval_i          - fold the current tap into the window
//            tap_i           - tap under test
//            found_o         - a window has been opened
//            center_o        - floor((first+last)/2), 0 without a window
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module adc_lane_window #(
    parameter int TAP_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             load_i,
    input  logic             check_i,
    input  logic             mismatch_i,
    input  logic             eval_i,
    input  logic [TAP_W-1:0] tap_i,
    output logic             found_o,
    output logic [TAP_W-1:0] center_o
);

    logic             pass_q;
    logic             open_q;
    logic             closed_q;
    logic [TAP_W-1:0] first_q;
    logic [TAP_W-1:0] last_q;
    logic [TAP_W:0]   sum;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pass_q   <= 1'b0;
            open_q   <= 1'b0;
            closed_q <= 1'b0;
            first_q  <= '0;
            last_q   <= '0;
        end else begin
            if (load_i) begin
                pass_q <= 1'b1;
            end else if (check_i && mismatch_i) begin
                pass_q <= 1'b0;
            end

            if (clr_i) begin
                open_q   <= 1'b0;
                closed_q <= 1'b0;
                first_q  <= '0;
                last_q   <= '0;
            end else if (eval_i && !closed_q) begin
                // Once closed, later passing taps never reopen: the first
                // contiguous window is the one that gets centred.
                if (pass_q) begin
                    if (!open_q) begin
                        first_q <= tap_i;
                        open_q  <= 1'b1;
                    end
                    last_q <= tap_i;
                end else if (open_q) begin
                    open_q   <= 1'b0;
                    closed_q <= 1'b1;
                end
            end
        end
    end

    // Extra sum bit keeps (31+31)/2 from wrapping.
    assign sum      = {1'b0, first_q} + {1'b0, last_q};
    assign found_o  = open_q | closed_q;
    assign center_o = found_o ? sum[TAP_W:1] : '0;

endmodule

`default_nettype wire

// File: rtl/adc_lane_align.sv
// ============================================================================
// Module   : adc_lane_align
// Purpose  : Sweeps a shared IDELAY tap over all values, checks each DDR lane
//            against fixed rise/fall training words, and loads every lane with
//            the centre of its first passing window.
// Ports    : clk, rst               - DCO clock, async active-high reset
//            data_p, data_n         - rise/fall IDDR samples per lane
//            start                  - training start pulse
//            delay_ld, delay_wdata  - tap load strobe and per-lane taps
//            sample                 - registered {data_n, data_p}
//            busy, done, fail       - status
//            lane_ok                - per-lane window found
//            err_cnt                - (ADC_ALIGN_ERRCNT_EN only) saturating
//                                     lane-cycle mismatch count
// Config   : define ADC_ALIGN_ERRCNT_EN to add err_cnt.
// Notes    : SETTLE_CYCLES and CHECK_CYCLES must be at least 1.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module adc_lane_align
    import adc_if_pkg::*;
#(
    parameter int                   NUM_LANES     = 8,
    parameter int                   TAP_W         = 5,
    parameter int                   SETTLE_CYCLES = 16,
    parameter int                   CHECK_CYCLES  = 64,
    parameter logic [NUM_LANES-1:0] PATTERN_P     = NUM_LANES'(DEF_PATTERN_P),
    parameter logic [NUM_LANES-1:0] PATTERN_N     = NUM_LANES'(DEF_PATTERN_N)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_LANES-1:0]       data_p,
    input  logic [NUM_LANES-1:0]       data_n,
    input  logic                       start,
    output logic                       delay_ld,
    output logic [NUM_LANES*TAP_W-1:0] delay_wdata,
    output logic [2*NUM_LANES-1:0]     sample,
    output logic                       busy,
    output logic                       done,
    output logic                       fail,
    output logic [NUM_LANES-1:0]       lane_ok
`ifdef ADC_ALIGN_ERRCNT_EN
    ,
    output logic [15:0]                err_cnt
`endif
);

    localparam int CNT_MAX = (SETTLE_CYCLES > CHECK_CYCLES) ? SETTLE_CYCLES : CHECK_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [TAP_W-1:0] TAP_LAST = {TAP_W{1'b1}};

    align_state_t         state_q, state_d;
    logic [TAP_W-1:0]     tap_q, tap_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [2*NUM_LANES-1:0] sample_q;
    logic                 done_q, fail_q;
    logic [NUM_LANES-1:0] lane_ok_q;

    logic                 win_clr, win_load, win_chk, win_eval;
    logic [NUM_LANES-1:0] lane_mis;
    logic [NUM_LANES-1:0] lane_found;
    logic [NUM_LANES*TAP_W-1:0] lane_center;

    assign lane_mis = (data_p ^ PATTERN_P) | (data_n ^ PATTERN_N);

    generate
        for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
            adc_lane_window #(
                .TAP_W (TAP_W)
            ) u_win (
                .clk        (clk),
                .rst        (rst),
                .clr_i      (win_clr),
                .load_i     (win_load),
                .check_i    (win_chk),
                .mismatch_i (lane_mis[i]),
                .eval_i     (win_eval),
                .tap_i      (tap_q),
                .found_o    (lane_found[i]),
                .center_o   (lane_center[i*TAP_W +: TAP_W])
            );
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            tap_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            tap_q   <= tap_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        tap_d       = tap_q;
        cnt_d       = cnt_q;
        win_clr     = 1'b0;
        win_load    = 1'b0;
        win_chk     = 1'b0;
        win_eval    = 1'b0;
        delay_ld    = 1'b0;
        delay_wdata = '0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    tap_d   = '0;
                    win_clr = 1'b1;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                delay_ld    = 1'b1;
                delay_wdata = {NUM_LANES{tap_q}};
                win_load    = 1'b1;
                cnt_d       = '0;
                state_d     = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (cnt_q == CNT_W'(SETTLE_CYCLES - 1)) begin
                    cnt_d   = '0;
                    state_d = ST_CHECK;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_CHECK: begin
                win_chk = 1'b1;
                if (cnt_q == CNT_W'(CHECK_CYCLES - 1)) begin
                    cnt_d   = '0;
                    state_d = ST_EVAL;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_EVAL: begin
                win_eval = 1'b1;
                if (tap_q == TAP_LAST) begin
                    state_d = ST_APPLY;
                end else begin
                    tap_d   = tap_q + 1'b1;
                    state_d = ST_LOAD;
                end
            end
            ST_APPLY: begin
                delay_ld    = 1'b1;
                delay_wdata = lane_center;
                state_d     = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Status is captured at the end of APPLY, so lane_ok/fail become valid
    // together with the done pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sample_q  <= '0;
            done_q    <= 1'b0;
            fail_q    <= 1'b0;
            lane_ok_q <= '0;
        end else begin
            sample_q <= {data_n, data_p};
            done_q   <= (state_q == ST_APPLY);
            if (win_clr) begin
                fail_q    <= 1'b0;
                lane_ok_q <= '0;
            end else if (state_q == ST_APPLY) begin
                lane_ok_q <= lane_found;
                fail_q    <= ~&lane_found;
            end
        end
    end

    assign sample  = sample_q;
    assign busy    = (state_q != ST_IDLE);
    assign done    = done_q;
    assign fail    = fail_q;
    assign lane_ok = lane_ok_q;

`ifdef ADC_ALIGN_ERRCNT_EN
    localparam int POP_W = $clog2(NUM_LANES + 1);

    logic [15:0]      err_cnt_q;
    logic [POP_W-1:0] mis_pop;
    logic [16:0]      err_sum;

    always_comb begin
        mis_pop = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            mis_pop = mis_pop + POP_W'(lane_mis[i]);
        end
    end

    assign err_sum = {1'b0, err_cnt_q} + 17'(mis_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_cnt_q <= '0;
        end else if (win_clr) begin
            err_cnt_q <= '0;
        end else if (win_chk) begin
            err_cnt_q <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
        end
    end

    assign err_cnt = err_cnt_q;
`endif

endmodule

`default_nettype wire
